uart_baud_gen: RTL and testbench
================================

# uart_baud_gen

Dual-channel, runtime-programmable baud-rate generator for the UART datapath, replacing fixed single-rate bit-clock generators. Independent TX and RX channels share one fractional divisor (integer + fractional clocks per bit), so any baud rate from a fixed `clk` is reachable with bounded jitter. The RX channel adds a mid-bit sample strobe and a resync input for start-bit alignment. Divisor changes are glitch-free and applied only at bit-period boundaries.

## Interface
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 8: fractional divisor width.
- `DEF_DIV_INT`, 5208: reset integer divisor (50 MHz / 9600).
- `DEF_DIV_FRAC`, 0: reset fractional divisor.
- `MIN_DIV`, 4: smallest legal integer divisor.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_wr` in 1: one-cycle pulse; loads `cfg_div_int` and `cfg_div_frac` into the shadow divisor.
- `cfg_div_int` in `DIV_W`: integer clocks per bit.
- `cfg_div_frac` in `FRAC_W`: fractional clocks per bit, in units of 1/2^`FRAC_W`.
- `cfg_err` out 1: one-cycle pulse; `cfg_wr` rejected.
- `tx_en` in 1: TX channel run.
- `tx_tick` out 1: one-cycle pulse at the end of each TX bit period.
- `rx_en` in 1: RX channel run.
- `rx_resync` in 1: restart the RX period at count 0.
- `rx_sample` out 1: one-cycle pulse at mid-bit.
- `rx_tick` out 1: one-cycle pulse at the end of each RX bit period.

## Operation
- **Shadow divisor.** Reset value is {`DEF_DIV_INT`, `DEF_DIV_FRAC`}.
  - `cfg_wr` with `cfg_div_int` < `MIN_DIV`: ignored; `cfg_err` is high in the next cycle.
  - Otherwise the shadow is updated at that edge.
- **Channel divisor.** Each channel holds an active divisor copy. It reloads from the shadow:
  - while the channel is disabled, continuously;
  - at each period start while the channel is enabled.
  - A divisor change therefore never alters a period already in progress.
- **Period length.** At each period start, `acc_next = acc + frac`, computed as an (`FRAC_W`+1)-bit sum.
  - Period length P = `div_int` + carry.
  - `acc` keeps the low `FRAC_W` bits.
  - `acc` clears to 0 while the channel is disabled.
- **Counter.** `cnt` (`DIV_W`+1 bits) is 0 while disabled. On each enabled edge, `cnt` increments and wraps to 0 after reaching P-1. The wrap edge is a period start.
- **TX channel.** `tx_tick` is registered and high for the cycle after the edge where `cnt` == P-1.
- **RX channel.** Same counter scheme as TX, plus:
  - `rx_sample` is registered and high for the cycle after the edge where `cnt` == floor(P/2)-1.
  - `rx_tick` follows the TX rule.
  - `rx_resync` while `rx_en` is high forces `cnt`=0 and starts a new period: divisor reload and acc update apply. No pulse is produced that edge.
  - `rx_resync` has priority over the count.
- **Disable mid-period.** `cnt` clears at the next edge and no pulse is produced. Re-enable starts a fresh period.
- **Reset mid-operation.** All state returns to reset values immediately (asynchronous).

## Timing
- All outputs are registered and 0 during and after reset: `tx_tick`, `rx_tick`, `rx_sample`, `cfg_err`.
- **First `tx_tick`:** in the cycle after the P-th rising edge with `tx_en` sampled high.
- **First `rx_sample`:** after the floor(P/2)-th enabled edge. With P=5208, that is the 2604th edge.
- **`cfg_err` latency:** 1 cycle.
- **Shadow-to-output latency:** a new divisor takes effect at the next period start, so at most one old-length period follows.
- **Simultaneous `cfg_wr` and period start:** the channel loads the *old* shadow. The new value applies one period later.

## Structure
- Package `uart_baud_pkg`:
  - `DIV_W`, `FRAC_W`, `MIN_DIV` defaults;
  - `div_t` struct {`int_part`, `frac_part`};
  - default divisor constant.
- Sub-module `baud_chan`, instanced twice (TX with `rx_resync` tied 0 and `rx_sample` unused; RX). It contains:
  - the active divisor;
  - the accumulator;
  - the counter;
  - the `tick`/`mid` registers.
- The top level holds only the shadow register and the `cfg_err` logic.

## Test plan
- Reset, `tx_en`=1 with default divisor → first `tx_tick` at enabled edge 5208 + 1 cycle, then every 5208 cycles; `rx_en`=1 → `rx_sample` after edge 2604.
- `cfg_wr` int=10, frac=128 (`FRAC_W`=8), `tx_en`=1 → `tx_tick` periods 10, 11, 10, 11.
- `cfg_wr` int=3 → `cfg_err` pulse next cycle; periods unchanged.
- TX running at int=10; `cfg_wr` int=20 at `cnt`=4 → current period completes at 10, following periods are 20.
- RX at int=16: `rx_resync` at `cnt`=9 → next `rx_sample` 8 edges later, `rx_tick` 16 edges later; no pulse on the resync edge.
- `rx_en` dropped at `cnt`=7, then reasserted; `rst_n` pulsed mid-period → no stray pulses; full period restarts; all outputs 0 after reset.

Source files
------------

// File: rtl/uart_baud_gen_pkg.sv
// uart_baud_pkg: shared widths, limits and the default divisor for uart_baud_gen.
//   DIV_W / FRAC_W : integer / fractional divisor widths
//   MIN_DIV        : smallest integer divisor accepted on a config write
//   div_t          : packed divisor payload {int_part, frac_part}
//   DEF_DIV        : divisor loaded at reset (50 MHz / 9600)
package uart_baud_pkg;

   localparam int unsigned DIV_W        = 16;
   localparam int unsigned FRAC_W       = 8;
   localparam int unsigned MIN_DIV      = 4;
   localparam int unsigned DEF_DIV_INT  = 5208;
   localparam int unsigned DEF_DIV_FRAC = 0;

   typedef struct packed {
      logic [DIV_W-1:0]  int_part;
      logic [FRAC_W-1:0] frac_part;
   } div_t;

   localparam div_t DEF_DIV = '{int_part:  DIV_W'(DEF_DIV_INT),
                                frac_part: FRAC_W'(DEF_DIV_FRAC)};

endpackage : uart_baud_pkg

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: divisor configuration bus.
//   cfg_wr       : one-cycle write strobe (master -> slave)
//   cfg_div_int  : integer clocks per bit
//   cfg_div_frac : fractional clocks per bit, units of 1/2^FRAC_W
//   cfg_err      : one-cycle reject pulse (slave -> master)
interface uart_baud_gen_if #(
   parameter int unsigned DIV_W  = uart_baud_pkg::DIV_W,
   parameter int unsigned FRAC_W = uart_baud_pkg::FRAC_W
);
   logic              cfg_wr;
   logic [DIV_W-1:0]  cfg_div_int;
   logic [FRAC_W-1:0] cfg_div_frac;
   logic              cfg_err;

   modport master (output cfg_wr, output cfg_div_int, output cfg_div_frac, input  cfg_err);
   modport slave  (input  cfg_wr, input  cfg_div_int, input  cfg_div_frac, output cfg_err);
endinterface : uart_baud_gen_if

// File: rtl/uart_baud_gen_chan.sv
// baud_chan: one fractional bit-period timer.
//   clk, rst_n  : clock, async active-low reset
//   en          : channel run; low clears the period and tracks the shadow divisor
//   resync      : restart the period at count 0 (ignored while en is low)
//   sh_int/frac : shadow divisor, sampled only at period starts
//   tick        : registered pulse after the last edge of a period
//   mid         : registered pulse after edge floor(P/2) of a period
module baud_chan #(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned FRAC_W   = 8,
   parameter int unsigned DEF_INT  = 5208,
   parameter int unsigned DEF_FRAC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              resync,
   input  logic [DIV_W-1:0]  sh_int,
   input  logic [FRAC_W-1:0] sh_frac,
   output logic              tick,
   output logic              mid
);

   localparam int unsigned CNT_W = DIV_W + 1;

   logic [DIV_W-1:0]  act_int;
   logic [FRAC_W-1:0] act_frac;
   // Accumulator value before this period's add; the add itself is combinational
   // so the carry that lengthens the current period is always available.
   logic [FRAC_W-1:0] acc;
   logic [CNT_W-1:0]  cnt;

   logic [FRAC_W:0]   sum_c;
   logic [CNT_W-1:0]  per_c;
   logic [CNT_W-1:0]  last_c;
   logic [CNT_W-1:0]  half_c;
   logic              wrap_c;
   logic              start_c;

   // Current period length and the compare points derived from it.
   always_comb begin
      sum_c   = {1'b0, acc} + {1'b0, act_frac};
      per_c   = {1'b0, act_int} + CNT_W'(sum_c[FRAC_W]);
      last_c  = per_c - CNT_W'(1);
      half_c  = (per_c >> 1) - CNT_W'(1);
      wrap_c  = (cnt == last_c);
      start_c = resync | wrap_c;
   end

   // Counter, active divisor, accumulator and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_int  <= DIV_W'(DEF_INT);
         act_frac <= FRAC_W'(DEF_FRAC);
         acc      <= '0;
         cnt      <= '0;
         tick     <= 1'b0;
         mid      <= 1'b0;
      end else if (!en) begin
         act_int  <= sh_int;
         act_frac <= sh_frac;
         acc      <= '0;
         cnt      <= '0;
         tick     <= 1'b0;
         mid      <= 1'b0;
      end else begin
         // A resync edge never emits a pulse, even if it lands on a compare point.
         tick <= wrap_c & ~resync;
         mid  <= (cnt == half_c) & ~resync;
         if (start_c) begin
            cnt      <= '0;
            act_int  <= sh_int;
            act_frac <= sh_frac;
            acc      <= sum_c[FRAC_W-1:0];
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule : baud_chan

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: dual-channel programmable fractional baud-rate generator.
//   clk, rst_n : clock, async active-low reset
//   cfg        : divisor write bus (slave); rejects cfg_div_int < MIN_DIV with cfg_err
//   tx_en      : TX run;  tx_tick  pulses at the end of each TX bit period
//   rx_en      : RX run;  rx_tick  pulses at the end of each RX bit period
//   rx_resync  : restart the RX period;  rx_sample pulses at mid-bit
module uart_baud_gen #(
   parameter int unsigned DIV_W        = uart_baud_pkg::DIV_W,
   parameter int unsigned FRAC_W       = uart_baud_pkg::FRAC_W,
   parameter int unsigned DEF_DIV_INT  = uart_baud_pkg::DEF_DIV_INT,
   parameter int unsigned DEF_DIV_FRAC = uart_baud_pkg::DEF_DIV_FRAC,
   parameter int unsigned MIN_DIV      = uart_baud_pkg::MIN_DIV
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_baud_gen_if.slave cfg,
   input  logic           tx_en,
   output logic           tx_tick,
   input  logic           rx_en,
   input  logic           rx_resync,
   output logic           rx_sample,
   output logic           rx_tick
);

   logic [DIV_W-1:0]  sh_int;
   logic [FRAC_W-1:0] sh_frac;
   logic              cfg_ok_c;
   logic              tx_mid_unused;

   assign cfg_ok_c = (cfg.cfg_div_int >= DIV_W'(MIN_DIV));

   // Shadow divisor and reject pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_int      <= DIV_W'(DEF_DIV_INT);
         sh_frac     <= FRAC_W'(DEF_DIV_FRAC);
         cfg.cfg_err <= 1'b0;
      end else begin
         cfg.cfg_err <= cfg.cfg_wr & ~cfg_ok_c;
         if (cfg.cfg_wr && cfg_ok_c) begin
            sh_int  <= cfg.cfg_div_int;
            sh_frac <= cfg.cfg_div_frac;
         end
      end
   end

   baud_chan #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEF_INT(DEF_DIV_INT), .DEF_FRAC(DEF_DIV_FRAC)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (tx_en),
      .resync  (1'b0),
      .sh_int  (sh_int),
      .sh_frac (sh_frac),
      .tick    (tx_tick),
      .mid     (tx_mid_unused)
   );

   baud_chan #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEF_INT(DEF_DIV_INT), .DEF_FRAC(DEF_DIV_FRAC)
   ) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rx_en),
      .resync  (rx_resync),
      .sh_int  (sh_int),
      .sh_frac (sh_frac),
      .tick    (rx_tick),
      .mid     (rx_sample)
   );

endmodule : uart_baud_gen

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_baud_gen;
   import uart_baud_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic tx_en = 1'b0;
   logic rx_en = 1'b0;
   logic rx_resync = 1'b0;
   logic tx_tick, rx_sample, rx_tick;

   int vectors     = 0;
   int miscompares = 0;
   int n_tx  = 0;
   int n_rx  = 0;
   int n_smp = 0;

   always #5 clk = ~clk;

   uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) cfg_if ();

   uart_baud_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg       (cfg_if),
      .tx_en     (tx_en),
      .tx_tick   (tx_tick),
      .rx_en     (rx_en),
      .rx_resync (rx_resync),
      .rx_sample (rx_sample),
      .rx_tick   (rx_tick)
   );

   // Running pulse counts, for windows that must stay quiet.
   always @(negedge clk) begin
      if (tx_tick   === 1'b1) n_tx++;
      if (rx_tick   === 1'b1) n_rx++;
      if (rx_sample === 1'b1) n_smp++;
   end

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Counts rising edges until the selected output is seen high; -1 if the budget expires.
   task automatic wait_pulse(input int sel, input int budget, output int n);
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         case (sel)
            0:       hit = (tx_tick   === 1'b1);
            1:       hit = (rx_tick   === 1'b1);
            2:       hit = (rx_sample === 1'b1);
            default: hit = (cfg_if.cfg_err === 1'b1);
         endcase
      end
      if (!hit) n = -1;
   endtask

   task automatic write_cfg(input int unsigned di, input int unsigned df);
      cfg_if.cfg_wr       = 1'b1;
      cfg_if.cfg_div_int  = DIV_W'(di);
      cfg_if.cfg_div_frac = FRAC_W'(df);
      step(1);
      cfg_if.cfg_wr = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] outs;
      #1 rst_n = 1'b0;
      #2;
      outs = {tx_tick, rx_tick, rx_sample, cfg_if.cfg_err};
      vectors++;
      if (outs !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b, expected 0000", outs);
      end
      step(3);
      rst_n = 1'b1;
      step(3);
      outs = {tx_tick, rx_tick, rx_sample, cfg_if.cfg_err};
      vectors++;
      if (outs !== 4'b0000) begin
         miscompares++;
         $display("FAIL post_reset_idle: got %b, expected 0000", outs);
      end
   endtask

   task automatic test_default();
      int n;
      tx_en = 1'b1;
      rx_en = 1'b1;
      wait_pulse(2, 3000, n);
      vectors++;
      if (n !== 2604) begin
         miscompares++;
         $display("FAIL default_first_sample: got %0d edges, expected 2604", n);
      end
      wait_pulse(0, 3000, n);
      vectors++;
      if (n !== 2604) begin
         miscompares++;
         $display("FAIL default_first_tx_tick: got %0d more edges, expected 2604", n);
      end
      vectors++;
      if (rx_tick !== 1'b1) begin
         miscompares++;
         $display("FAIL default_first_rx_tick: got %b, expected 1", rx_tick);
      end
      wait_pulse(0, 6000, n);
      vectors++;
      if (n !== 5208) begin
         miscompares++;
         $display("FAIL default_tx_period: got %0d, expected 5208", n);
      end
      tx_en = 1'b0;
      rx_en = 1'b0;
      step(2);
   endtask

   task automatic test_frac();
      int n;
      int base;
      int exp_p[4] = '{10, 11, 10, 11};
      write_cfg(10, 128);
      step(1);
      tx_en = 1'b1;
      #1 base = n_tx;
      for (int i = 0; i < 4; i++) begin
         wait_pulse(0, 40, n);
         vectors++;
         if (n !== exp_p[i]) begin
            miscompares++;
            $display("FAIL frac_period[%0d]: got %0d, expected %0d", i, n, exp_p[i]);
         end
      end
      #1;
      vectors++;
      if (n_tx - base !== 4) begin
         miscompares++;
         $display("FAIL frac_tick_count: got %0d, expected 4", n_tx - base);
      end
      tx_en = 1'b0;
      step(2);
   endtask

   task automatic test_cfg_err();
      int n;
      write_cfg(10, 0);
      step(1);
      tx_en = 1'b1;
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 10) begin
         miscompares++;
         $display("FAIL err_base_period: got %0d, expected 10", n);
      end
      cfg_if.cfg_wr       = 1'b1;
      cfg_if.cfg_div_int  = DIV_W'(3);
      cfg_if.cfg_div_frac = FRAC_W'(0);
      step(1);
      vectors++;
      if (cfg_if.cfg_err !== 1'b1) begin
         miscompares++;
         $display("FAIL cfg_err_pulse: got %b, expected 1", cfg_if.cfg_err);
      end
      cfg_if.cfg_wr = 1'b0;
      step(1);
      vectors++;
      if (cfg_if.cfg_err !== 1'b0) begin
         miscompares++;
         $display("FAIL cfg_err_width: got %b, expected 0", cfg_if.cfg_err);
      end
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL err_period_rest: got %0d, expected 8", n);
      end
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 10) begin
         miscompares++;
         $display("FAIL err_period_after: got %0d, expected 10", n);
      end
   endtask

   // Continues the TX run at divisor 10, aligned just after a tick.
   task automatic test_midperiod_change();
      int n;
      step(4);
      write_cfg(20, 0);
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 5) begin
         miscompares++;
         $display("FAIL change_current_period: got %0d remaining, expected 5", n);
      end
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 20) begin
         miscompares++;
         $display("FAIL change_new_period: got %0d, expected 20", n);
      end
      // Write on the wrap edge: the period starting there keeps the old length.
      step(19);
      cfg_if.cfg_wr       = 1'b1;
      cfg_if.cfg_div_int  = DIV_W'(10);
      cfg_if.cfg_div_frac = FRAC_W'(0);
      wait_pulse(0, 4, n);
      cfg_if.cfg_wr = 1'b0;
      vectors++;
      if (n !== 1) begin
         miscompares++;
         $display("FAIL wrap_write_tick: got %0d, expected 1", n);
      end
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 20) begin
         miscompares++;
         $display("FAIL wrap_write_old_period: got %0d, expected 20", n);
      end
      wait_pulse(0, 40, n);
      vectors++;
      if (n !== 10) begin
         miscompares++;
         $display("FAIL wrap_write_new_period: got %0d, expected 10", n);
      end
      tx_en = 1'b0;
      step(2);
   endtask

   task automatic test_resync();
      int n;
      write_cfg(16, 0);
      step(1);
      rx_en = 1'b1;
      wait_pulse(1, 40, n);
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL rx16_first_tick: got %0d, expected 16", n);
      end
      step(9);
      rx_resync = 1'b1;
      step(1);
      rx_resync = 1'b0;
      vectors++;
      if ({rx_sample, rx_tick} !== 2'b00) begin
         miscompares++;
         $display("FAIL resync_edge_quiet: got %b, expected 00", {rx_sample, rx_tick});
      end
      wait_pulse(2, 40, n);
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL resync_sample: got %0d, expected 8", n);
      end
      wait_pulse(1, 40, n);
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL resync_tick: got %0d more, expected 8", n);
      end
      // Resync on the edge that would have ended the period suppresses the tick.
      step(15);
      rx_resync = 1'b1;
      step(1);
      rx_resync = 1'b0;
      vectors++;
      if (rx_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL resync_wrap_quiet: got %b, expected 0", rx_tick);
      end
      wait_pulse(1, 40, n);
      vectors++;
      if (n !== 16) begin
         miscompares++;
         $display("FAIL resync_wrap_period: got %0d, expected 16", n);
      end
   endtask

   // Continues the RX run at divisor 16, aligned just after a tick.
   task automatic test_disable_reset();
      int n;
      int b_smp;
      int b_rx;
      step(7);
      rx_en = 1'b0;
      #1;
      b_smp = n_smp;
      b_rx  = n_rx;
      step(20);
      #1;
      vectors++;
      if ((n_smp - b_smp) !== 0 || (n_rx - b_rx) !== 0) begin
         miscompares++;
         $display("FAIL disable_quiet: got %0d samples %0d ticks, expected 0 0",
                  n_smp - b_smp, n_rx - b_rx);
      end
      rx_en = 1'b1;
      wait_pulse(2, 40, n);
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL reenable_sample: got %0d, expected 8", n);
      end
      wait_pulse(1, 40, n);
      vectors++;
      if (n !== 8) begin
         miscompares++;
         $display("FAIL reenable_tick: got %0d more, expected 8", n);
      end
      // Reset while rx_tick is high: it must drop without waiting for a clock edge.
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({tx_tick, rx_tick, rx_sample, cfg_if.cfg_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL async_reset_outputs: got %b, expected 0000",
                  {tx_tick, rx_tick, rx_sample, cfg_if.cfg_err});
      end
      @(negedge clk);
      step(3);
      rst_n = 1'b1;
      // Shadow is back at 5208, so the restarted RX period samples at edge 2604.
      wait_pulse(2, 3000, n);
      vectors++;
      if (n !== 2604) begin
         miscompares++;
         $display("FAIL post_reset_sample: got %0d, expected 2604", n);
      end
      rx_en = 1'b0;
      step(2);
   endtask

   initial begin
      cfg_if.cfg_wr       = 1'b0;
      cfg_if.cfg_div_int  = '0;
      cfg_if.cfg_div_frac = '0;
      test_reset();
      test_default();
      test_frac();
      test_cfg_err();
      test_midperiod_change();
      test_resync();
      test_disable_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_baud_gen
